// File: rtl/fasttwosum_seq_ctrl.sv
// Sequencer for one fasttwosum_step: holds operands for STEP_LAT edges, accumulates sum/error, emits per-vector result.
// Optional macro FASTTWOSUM_SEQ_COMPENSATE_EN folds the error term into the result sum one cycle after capture.
module fasttwosum_seq_ctrl #(
   parameter int EXP_WIDTH_I  = 5,
   parameter int MANT_WIDTH_I = 2,
   parameter int STEP_LAT     = 6,
   parameter int CNT_WIDTH    = 16,
   localparam int BIT_WIDTH_I = 1 + EXP_WIDTH_I + MANT_WIDTH_I
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   elem_valid_i,
   output logic                   elem_ready_o,
   input  logic [BIT_WIDTH_I-1:0] elem_i,
   input  logic                   elem_last_i,
   output logic [BIT_WIDTH_I-1:0] step_elem_o,
   output logic [BIT_WIDTH_I-1:0] step_sum_o,
   output logic [BIT_WIDTH_I-1:0] step_error_o,
   input  logic [BIT_WIDTH_I-1:0] step_sum_i,
   input  logic [BIT_WIDTH_I-1:0] step_error_i,
   output logic                   res_valid_o,
   input  logic                   res_ready_i,
   output logic [BIT_WIDTH_I-1:0] res_sum_o,
   output logic [BIT_WIDTH_I-1:0] res_error_o,
   output logic [CNT_WIDTH-1:0]   res_count_o
);

   localparam int HCW = (STEP_LAT > 2) ? $clog2(STEP_LAT) : 1;
   localparam logic [HCW-1:0] HOLD_LAST = HCW'(STEP_LAT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      ADD  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t                 state;
   logic [HCW-1:0]         hold_cnt;
   logic                   last_q;
   logic                   ready_q;
   logic                   valid_q;
   logic [BIT_WIDTH_I-1:0] elem_q;
   logic [BIT_WIDTH_I-1:0] acc_sum;
   logic [BIT_WIDTH_I-1:0] acc_err;
   logic [CNT_WIDTH-1:0]   count;
`ifdef FASTTWOSUM_SEQ_COMPENSATE_EN
   logic [BIT_WIDTH_I-1:0] comp_sum;
`endif

   // The step sees the element register and the accumulators directly; both stay frozen outside capture/clear.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= IDLE;
         hold_cnt <= '0;
         last_q   <= 1'b0;
         ready_q  <= 1'b1;
         valid_q  <= 1'b0;
         elem_q   <= '0;
         acc_sum  <= '0;
         acc_err  <= '0;
         count    <= '0;
`ifdef FASTTWOSUM_SEQ_COMPENSATE_EN
         comp_sum <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (elem_valid_i) begin
                  elem_q   <= elem_i;
                  last_q   <= elem_last_i;
                  hold_cnt <= '0;
                  ready_q  <= 1'b0;
                  state    <= HOLD;
               end
            end
            HOLD: begin
               if (hold_cnt == HOLD_LAST) begin
                  acc_sum <= step_sum_i;
                  acc_err <= step_error_i;
                  count   <= (&count) ? count : count + 1'b1;
                  if (last_q) begin
`ifdef FASTTWOSUM_SEQ_COMPENSATE_EN
                     state   <= ADD;
`else
                     state   <= DONE;
                     valid_q <= 1'b1;
`endif
                  end else begin
                     state   <= IDLE;
                     ready_q <= 1'b1;
                  end
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
`ifdef FASTTWOSUM_SEQ_COMPENSATE_EN
            ADD: begin
               comp_sum <= acc_sum + acc_err;
               valid_q  <= 1'b1;
               state    <= DONE;
            end
`endif
            DONE: begin
               if (res_ready_i) begin
                  acc_sum <= '0;
                  acc_err <= '0;
                  count   <= '0;
                  elem_q  <= '0;
`ifdef FASTTWOSUM_SEQ_COMPENSATE_EN
                  comp_sum <= '0;
`endif
                  valid_q <= 1'b0;
                  ready_q <= 1'b1;
                  state   <= IDLE;
               end
            end
            default: begin
               state   <= IDLE;
               ready_q <= 1'b1;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign elem_ready_o = ready_q;
   assign res_valid_o  = valid_q;
   assign step_elem_o  = elem_q;
   assign step_sum_o   = acc_sum;
   assign step_error_o = acc_err;
   assign res_count_o  = count;
`ifdef FASTTWOSUM_SEQ_COMPENSATE_EN
   assign res_sum_o    = comp_sum;
   assign res_error_o  = '0;
`else
   assign res_sum_o    = acc_sum;
   assign res_error_o  = acc_err;
`endif

endmodule
